mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory stage downstream of the ALU: takes the effective address (alu_result, byte_offset) and
//  performs one load/store on the Avalon-MM data bus per request. Builds byteenable/writedata,
//  holds the bus stable through waitrequest, then extracts, extends or merges load data (incl. LWL/LWR).
//  busy stalls the pipeline. Little-endian: byte k = bus[8k+7:8k].
// PARAMETERS
//  TIMEOUT_CYCLES  255  max waitrequest cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset_n       in   1   synchronous reset, active low
//  start         in   1   request valid; accepted only in IDLE
//  mem_op        in   4   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,10 SW; others = no-op
//  alu_result    in   32  effective address from ALU
//  byte_offset   in   2   address bits [1:0] from ALU
//  store_data    in   32  rt value for stores
//  rt_old        in   32  current rt value for LWL/LWR merge
//  address       out  32  {alu_result[31:2],2'b00} latched at accept
//  read          out  1   Avalon read
//  write         out  1   Avalon write
//  byteenable    out  4   Avalon byte enables
//  writedata     out  32  Avalon write data
//  readdata      in   32  Avalon read data
//  waitrequest   in   1   Avalon stall
//  busy          out  1   state != IDLE
//  done          out  1   one-cycle completion pulse
//  load_result   out  32  final register value; valid with done when load_valid
//  load_valid    out  1   with done: rt write required
//  addr_error    out  1   with done: misaligned access, no bus cycle issued
//  bus_error     out  1   with done: timeout abort (0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; every output 0. Mid-access reset drops read/write next edge.
//  FSM IDLE -> ACCESS -> DONE -> IDLE. In IDLE, start with a valid mem_op latches all inputs.
//   Misaligned (LH/LHU/SH with byte_offset[0]=1; LW/SW with byte_offset!=0) -> DONE with addr_error=1.
//   Invalid mem_op -> ignored, stay IDLE.
//  ACCESS: read or write high, address/byteenable/writedata constant; leave when waitrequest=0
//   at the edge, capturing readdata. Minimum latency start->done = 2 cycles.
//  DONE: done=1 for exactly one cycle, flags/result valid, busy=1; next cycle IDLE, busy=0.
//  start while busy: ignored (no queueing). done/flags deassert in IDLE.
//  Store enables (k=byte_offset): SB be=1<<k, wd=store_data[7:0] replicated to all 4 lanes;
//   SH be=3<<k, wd={2{store_data[15:0]}}; SW be=4'hF, wd=store_data.
//  Loads read be=4'hF. LB/LBU: byte k sign/zero-extended. LH/LHU: half at k sign/zero-extended. LW: word.
//  LWL (word W, k): (W << 8*(3-k)) | (rt_old & (32'hFFFFFFFF >> 8*(k+1))); k=3 -> W.
//  LWR: (W >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)); k=0 -> W.
//  load_valid=1 only for a load completing without addr_error/bus_error.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: 8+ bit counter cleared on entering ACCESS, increments each cycle waitrequest=1;
//   reaching TIMEOUT_CYCLES drops read/write, goes DONE with bus_error=1, load_valid=0.
//  Not defined: no counter, ACCESS waits indefinitely, bus_error tied 0.
// TESTING
//  LW addr 0x100, readdata 0xDEADBEEF, waitrequest 0 -> read in cycle 1, done cycle 2, load_result 0xDEADBEEF.
//  LB addr 0x103, readdata 0x80AABBCC, waitrequest=1 for 3 cycles -> signals stable, done after, result 0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x202, store_data 0x1234ABCD -> address 0x200, byteenable 4'b1100, writedata 0xABCDABCD, load_valid 0.
//  LWL k=1 W=0x44332211 rt_old 0xAABBCCDD -> 0x2211CCDD; LWR k=1 -> 0xAA443322.
//  LW addr 0x101 -> no read asserted, done with addr_error=1; start pulsed during ACCESS ignored.
//  MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> read drops, done with bus_error=1; reset_n=0 mid-ACCESS -> IDLE, outputs 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing one Avalon-MM load/store per request.
// Builds byteenable/writedata, holds the bus through waitrequest, then extracts,
// extends or merges the load data (including LWL/LWR). Little-endian lanes.
// Optional feature macro: MEM_TIMEOUT_EN (waitrequest timeout abort with bus_error).
module mem_access_unit
`ifdef MEM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic        load_valid,
  output logic        addr_error,
  output logic        bus_error
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic [31:0] load_result_q, load_result_d;
  logic        load_valid_q, load_valid_d;
  logic        addr_error_q, addr_error_d;
  logic        bus_error_q, bus_error_d;
`ifdef MEM_TIMEOUT_EN
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  function automatic logic op_is_load(input logic [3:0] op);
    return (op <= OP_LWR);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] k);
    return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && k[0]) ||
           (((op == OP_LW) || (op == OP_SW)) && (k != 2'd0));
  endfunction

  // Final register value for a load of word w at byte offset k.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] k,
                                               input logic [31:0] w, input logic [31:0] rt);
    logic [15:0] lane;
    logic [4:0]  s8k;
    logic [4:0]  s8inv;
    logic [5:0]  s8k1;
    logic [31:0] res;
    s8k   = {k, 3'b000};
    s8inv = {~k, 3'b000};
    s8k1  = {1'b0, k, 3'b000} + 6'd8;
    lane  = 16'(w >> s8k);
    case (op)
      OP_LB:   res = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  res = {24'd0, lane[7:0]};
      OP_LH:   res = {{16{lane[15]}}, lane};
      OP_LHU:  res = {16'd0, lane};
      OP_LWL:  res = (w << s8inv) | (rt & (32'hFFFF_FFFF >> s8k1));
      OP_LWR:  res = (w >> s8k) | (rt & ~(32'hFFFF_FFFF >> s8k));
      default: res = w;
    endcase
    return res;
  endfunction

  // Next-state and registered-output logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    k_d           = k_q;
    rt_old_d      = rt_old_q;
    address_d     = address_q;
    read_d        = read_q;
    write_d       = write_q;
    be_d          = be_q;
    wd_d          = wd_q;
    done_d        = 1'b0;
    load_result_d = '0;
    load_valid_d  = 1'b0;
    addr_error_d  = 1'b0;
    bus_error_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (op_is_load(mem_op) || op_is_store(mem_op))) begin
          op_d      = mem_op;
          k_d       = byte_offset;
          rt_old_d  = rt_old;
          address_d = alu_result & ~32'd3;
          if (op_misaligned(mem_op, byte_offset)) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            addr_error_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
            if (op_is_store(mem_op)) begin
              write_d = 1'b1;
              case (mem_op)
                OP_SB: begin
                  be_d = 4'b0001 << byte_offset;
                  wd_d = {4{store_data[7:0]}};
                end
                OP_SH: begin
                  be_d = 4'b0011 << byte_offset;
                  wd_d = {2{store_data[15:0]}};
                end
                default: begin
                  be_d = 4'hF;
                  wd_d = store_data;
                end
              endcase
            end else begin
              read_d = 1'b1;
              be_d   = 4'hF;
            end
          end
        end
      end
      S_ACCESS: begin
        if (!waitrequest) begin
          state_d = S_DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
          be_d    = '0;
          wd_d    = '0;
          done_d  = 1'b1;
          if (op_is_load(op_q)) begin
            load_result_d = load_extract(op_q, k_q, readdata, rt_old_q);
            load_valid_d  = 1'b1;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d >= CntW'(TIMEOUT_CYCLES)) begin
            state_d     = S_DONE;
            read_d      = 1'b0;
            write_d     = 1'b0;
            be_d        = '0;
            wd_d        = '0;
            done_d      = 1'b1;
            bus_error_d = 1'b1;
          end
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      k_q           <= '0;
      rt_old_q      <= '0;
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      be_q          <= '0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_result_q <= '0;
      load_valid_q  <= 1'b0;
      addr_error_q  <= 1'b0;
      bus_error_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      k_q           <= k_d;
      rt_old_q      <= rt_old_d;
      address_q     <= address_d;
      read_q        <= read_d;
      write_q       <= write_d;
      be_q          <= be_d;
      wd_q          <= wd_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= done_d;
      load_result_q <= load_result_d;
      load_valid_q  <= load_valid_d;
      addr_error_q  <= addr_error_d;
      bus_error_q   <= bus_error_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign byteenable  = be_q;
  assign writedata   = wd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_result = load_result_q;
  assign load_valid  = load_valid_q;
  assign addr_error  = addr_error_q;
  assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a result scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mem_op;
  logic [31:0] alu_result;
  logic [1:0]  byte_offset;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        busy;
  logic        done;
  logic [31:0] load_result;
  logic        load_valid;
  logic        addr_error;
  logic        bus_error;

  typedef struct {
    logic        chk_res;
    logic [31:0] res;
    logic        lv;
    logic        ae;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_unit dut (
`endif
    .clk(clk), .reset_n(reset_n), .start(start), .mem_op(mem_op),
    .alu_result(alu_result), .byte_offset(byte_offset), .store_data(store_data),
    .rt_old(rt_old), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .busy(busy), .done(done), .load_result(load_result),
    .load_valid(load_valid), .addr_error(addr_error), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard entry and compare the completion flags/result.
  task automatic check_completion(input string tag);
    exp_t e;
    check({tag, ".done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".flags"}, {29'd0, load_valid, addr_error, bus_error},
            {29'd0, e.lv, e.ae, e.berr});
      if (e.chk_res) check({tag, ".result"}, load_result, e.res);
    end
  endtask

  // One request: drive, verify bus phase for nwait stall cycles, then completion.
  task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] sd, input logic [31:0] rt, input logic [31:0] rd,
                     input int nwait, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input logic exp_ae, input logic chk_res, input logic [31:0] exp_res,
                     input logic poke);
    exp_t e;
    logic is_st;
    logic [31:0] bus_exp;
    is_st     = op[3];
    e.chk_res = chk_res;
    e.res     = exp_res;
    e.lv      = !is_st && !exp_ae;
    e.ae      = exp_ae;
    e.berr    = 1'b0;
    sb_q.push_back(e);
    mem_op      = op;
    alu_result  = addr;
    byte_offset = addr[1:0];
    store_data  = sd;
    rt_old      = rt;
    readdata    = rd;
    waitrequest = (nwait != 0);
    start       = 1'b1;
    tick();
    start = 1'b0;
    if (exp_ae) begin
      check({tag, ".no_bus"}, {30'd0, read, write}, 32'd0);
    end else begin
      bus_exp = {26'd0, busy, !is_st, is_st, exp_be[2:0] == 3'd0 ? 1'b0 : 1'b1};
      check({tag, ".address"}, address, addr & ~32'd3);
      check({tag, ".rw_busy"}, {29'd0, busy, read, write}, {29'd0, 1'b1, !is_st, is_st});
      check({tag, ".be"}, 32'(byteenable), 32'(exp_be));
      if (is_st) check({tag, ".wd"}, writedata, exp_wd);
      for (int i = 0; i < nwait; i++) begin
        if (poke && i == 0) begin
          start      = 1'b1;
          mem_op     = 4'd10;
          alu_result = 32'h0000_0999;
        end
        tick();
        start = 1'b0;
        check({tag, ".hold_addr"}, address, addr & ~32'd3);
        check({tag, ".hold_ctl"}, {26'd0, read, write, byteenable},
              {26'd0, !is_st, is_st, exp_be});
      end
      waitrequest = 1'b0;
      tick();
      check({tag, ".rw_drop"}, {30'd0, read, write}, 32'd0);
    end
    check_completion(tag);
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    if (bus_exp[0] === 1'bx) check({tag, ".unused"}, 32'd0, 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    mem_op      = 4'd0;
    alu_result  = '0;
    byte_offset = '0;
    store_data  = '0;
    rt_old      = '0;
    readdata    = '0;
    waitrequest = 1'b0;
    repeat (3) tick();
    check("reset.addr_wd", address | writedata | load_result, 32'd0);
    check("reset.ctl", {23'd0, read, write, byteenable, busy, done, load_valid, addr_error, bus_error},
          32'd0);
    reset_n = 1'b1;
    tick();

    //   tag       op     addr          store_data    rt_old        readdata      nw be     wd            ae chk result        poke
    txn("lw",     4'd4,  32'h0000_0100, 32'h0,        32'h0,        32'hDEAD_BEEF, 0, 4'hF, 32'h0,        0, 1, 32'hDEAD_BEEF, 0);
    txn("lb",     4'd0,  32'h0000_0103, 32'h0,        32'h0,        32'h80AA_BBCC, 3, 4'hF, 32'h0,        0, 1, 32'hFFFF_FF80, 1);
    txn("lbu",    4'd1,  32'h0000_0103, 32'h0,        32'h0,        32'h80AA_BBCC, 3, 4'hF, 32'h0,        0, 1, 32'h0000_0080, 0);
    txn("sh",     4'd9,  32'h0000_0202, 32'h1234_ABCD, 32'h0,       32'h0,        0, 4'hC, 32'hABCD_ABCD, 0, 0, 32'h0,        0);
    txn("lwl1",   4'd5,  32'h0000_0101, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 4'hF, 32'h0,       0, 1, 32'h2211_CCDD, 0);
    txn("lwr1",   4'd6,  32'h0000_0101, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 4'hF, 32'h0,       0, 1, 32'hAA44_3322, 0);
    txn("lwl0",   4'd5,  32'h0000_0100, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 1, 4'hF, 32'h0,       0, 1, 32'h11BB_CCDD, 0);
    txn("lwl3",   4'd5,  32'h0000_0103, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 4'hF, 32'h0,       0, 1, 32'h4433_2211, 0);
    txn("lwr0",   4'd6,  32'h0000_0100, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 4'hF, 32'h0,       0, 1, 32'h4433_2211, 0);
    txn("lwr3",   4'd6,  32'h0000_0103, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 4'hF, 32'h0,       0, 1, 32'hAABB_CC44, 0);
    txn("lh",     4'd2,  32'h0000_0102, 32'h0,        32'h0,        32'h8001_1234, 2, 4'hF, 32'h0,        0, 1, 32'hFFFF_8001, 0);
    txn("lhu",    4'd3,  32'h0000_0102, 32'h0,        32'h0,        32'h8001_1234, 0, 4'hF, 32'h0,        0, 1, 32'h0000_8001, 0);
    txn("lh0",    4'd2,  32'h0000_0100, 32'h0,        32'h0,        32'h8001_7234, 0, 4'hF, 32'h0,        0, 1, 32'h0000_7234, 0);
    txn("sb",     4'd8,  32'h0000_0303, 32'h7777_775A, 32'h0,       32'h0,        1, 4'h8, 32'h5A5A_5A5A, 0, 0, 32'h0,        0);
    txn("sw",     4'd10, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,       32'h0,        0, 4'hF, 32'hCAFE_F00D, 0, 0, 32'h0,        0);
    txn("lw_mis", 4'd4,  32'h0000_0101, 32'h0,        32'h0,        32'h1111_1111, 0, 4'h0, 32'h0,        1, 0, 32'h0,        0);
    txn("sh_mis", 4'd9,  32'h0000_0201, 32'h1234_5678, 32'h0,       32'h0,        0, 4'h0, 32'h0,        1, 0, 32'h0,        0);

    // Undefined opcode is ignored: no busy, no bus cycle, no done.
    mem_op = 4'd7;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("invalid_op", {29'd0, busy, read, done}, 32'd0);
    tick();
    check("invalid_op2", {29'd0, busy, write, done}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      exp_t e;
      int   cyc;
      e.chk_res = 1'b0;
      e.res     = '0;
      e.lv      = 1'b0;
      e.ae      = 1'b0;
      e.berr    = 1'b1;
      sb_q.push_back(e);
      mem_op      = 4'd4;
      alu_result  = 32'h0000_0500;
      byte_offset = 2'd0;
      waitrequest = 1'b1;
      start       = 1'b1;
      tick();
      start = 1'b0;
      check("tmo.read", 32'(read), 32'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("tmo.bounded", 32'(cyc < 20), 32'd1);
      check("tmo.rw_drop", {30'd0, read, write}, 32'd0);
      check_completion("tmo");
      waitrequest = 1'b0;
      tick();
      check("tmo.idle", {30'd0, busy, done}, 32'd0);
    end
`endif

    // Reset in the middle of a stalled access clears the bus and all outputs.
    mem_op      = 4'd4;
    alu_result  = 32'h0000_0600;
    byte_offset = 2'd0;
    waitrequest = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check("rst_mid.read", {30'd0, read, busy}, 32'd3);
    reset_n = 1'b0;
    tick();
    check("rst_mid.addr", address | writedata | load_result, 32'd0);
    check("rst_mid.ctl", {23'd0, read, write, byteenable, busy, done, load_valid, addr_error, bus_error},
          32'd0);
    reset_n     = 1'b1;
    waitrequest = 1'b0;
    tick();
    check("rst_mid.idle", {29'd0, busy, read, done}, 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
